// File: rtl/ptp_ts_queue_if.sv
// Bus bundle between the PTP parser/timestamp source and the timestamp queue.
// The master side drives capture and queue controls; the slave side is the queue.
interface ptp_ts_queue_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic [63:0]         ts_in;
    logic                sop_valid;
    logic                ptp_found;
    logic [31:0]         ptp_infor;
    logic                q_rd;
    logic                q_clr;
    logic [95:0]         q_data;
    logic                q_empty;
    logic [DEPTH_LOG2:0] q_level;
    logic [7:0]          q_ovf_cnt;

    modport master (
        output ts_in, sop_valid, ptp_found, ptp_infor, q_rd, q_clr,
        input  q_data, q_empty, q_level, q_ovf_cnt
    );

    modport slave (
        input  ts_in, sop_valid, ptp_found, ptp_infor, q_rd, q_clr,
        output q_data, q_empty, q_level, q_ovf_cnt
    );
endinterface

// File: rtl/ptp_ts_queue.sv
// PTP event timestamp capture: latches ts_in at SOP, pairs it with parser info on the
// PTP-found rising edge, and queues {infor, ts} entries in a first-word fall-through FIFO.
module ptp_ts_queue #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic          clk,
    input  logic          rst,
    ptp_ts_queue_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  found_d1;
    logic                  found_rise;
    logic                  push_req;
    logic [63:0]           ts_hold;

    logic [95:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2:0]   level;
    logic [7:0]            ovf_cnt;
    logic                  empty;
    logic                  full;
    logic                  pop;
    logic                  wr_en;
    logic                  drop;

    // ---- capture stage: SOP timestamp hold and PTP-found edge detection ----
    assign found_rise = bus.ptp_found & ~found_d1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            found_d1 <= 1'b0;
        end else begin
            state    <= state_nxt;
            found_d1 <= bus.ptp_found;
        end
    end

    // A same-cycle SOP keeps the FSM armed; the push still pairs with the old ts_hold.
    always_comb begin
        state_nxt = state;
        push_req  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.sop_valid) state_nxt = ARMED;
            end
            ARMED: begin
                if (found_rise) begin
                    push_req  = 1'b1;
                    state_nxt = IDLE;
                end
                if (bus.sop_valid) state_nxt = ARMED;
            end
            default: state_nxt = IDLE;
        endcase
        if (bus.q_clr) begin
            state_nxt = IDLE;
            push_req  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_hold <= 64'd0;
        end else if (bus.sop_valid && !bus.q_clr) begin
            ts_hold <= bus.ts_in;
        end
    end

    // ---- queue stage: circular storage with level tracking ----
    assign empty = (level == '0);
    assign full  = (level == FULL_LVL);
    assign pop   = bus.q_rd & ~empty & ~bus.q_clr;
    assign wr_en = push_req & (~full | pop);
    assign drop  = push_req & full & ~pop;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {bus.ptp_infor, ts_hold};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            level   <= '0;
            ovf_cnt <= 8'd0;
        end else if (bus.q_clr) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            level   <= '0;
            ovf_cnt <= 8'd0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (drop && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 1'b1;
        end
    end

    // ---- output stage: fall-through head, forced to zero when empty ----
    assign bus.q_data    = empty ? 96'd0 : mem[rd_ptr];
    assign bus.q_empty   = empty;
    assign bus.q_level   = level;
    assign bus.q_ovf_cnt = ovf_cnt;
endmodule

// File: tb/tb_ptp_ts_queue.sv
// Self-checking bench for ptp_ts_queue: directed scenarios plus a random phase,
// all compared each cycle against a queue-based reference model.
module tb_ptp_ts_queue;
    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    ptp_ts_queue_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

    ptp_ts_queue #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [95:0] mq [$];
    int          m_ovf;
    bit          m_armed;
    logic [63:0] m_hold;
    bit          m_found_d1;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf      = 0;
        m_armed    = 0;
        m_hold     = 64'd0;
        m_found_d1 = 0;
    endtask

    // Apply one rising edge's worth of behaviour using the inputs currently driven.
    task automatic model_edge();
        bit          rise;
        bit          do_push;
        bit          do_pop;
        logic [95:0] entry;
        rise = bus.ptp_found && !m_found_d1;
        if (bus.q_clr) begin
            mq.delete();
            m_ovf   = 0;
            m_armed = 0;
        end else begin
            do_push = m_armed && rise;
            do_pop  = bus.q_rd && (mq.size() > 0);
            entry   = {bus.ptp_infor, m_hold};
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                if (mq.size() < DEPTH) mq.push_back(entry);
                else if (m_ovf < 255) m_ovf++;
            end
            if (bus.sop_valid) begin
                m_hold  = bus.ts_in;
                m_armed = 1;
            end else if (do_push) begin
                m_armed = 0;
            end
        end
        m_found_d1 = bus.ptp_found;
    endtask

    task automatic check_outputs();
        logic [95:0] exp_data;
        exp_data = (mq.size() > 0) ? mq[0] : 96'd0;
        check("q_empty", 96'(bus.q_empty), 96'(mq.size() == 0));
        check("q_level", 96'(bus.q_level), 96'(mq.size()));
        check("q_data", bus.q_data, exp_data);
        check("q_ovf_cnt", 96'(bus.q_ovf_cnt), 96'(m_ovf));
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic push_pkt(input logic [63:0] ts, input logic [31:0] infor, input bit rd);
        bus.sop_valid = 1'b1;
        bus.ts_in     = ts;
        cyc();
        bus.sop_valid = 1'b0;
        bus.ptp_found = 1'b1;
        bus.ptp_infor = infor;
        bus.q_rd      = rd;
        cyc();
        bus.ptp_found = 1'b0;
        bus.q_rd      = 1'b0;
        cyc();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.ts_in     = 64'd0;
        bus.sop_valid = 1'b0;
        bus.ptp_found = 1'b0;
        bus.ptp_infor = 32'd0;
        bus.q_rd      = 1'b0;
        bus.q_clr     = 1'b0;
        model_reset();

        // Reset state
        #3;
        check("rst_empty", 96'(bus.q_empty), 96'd1);
        check("rst_level", 96'(bus.q_level), 96'd0);
        check("rst_data", bus.q_data, 96'd0);
        check("rst_ovf", 96'(bus.q_ovf_cnt), 96'd0);
        #9 rst = 1'b0;

        // Basic capture: SOP, found 12 cycles later
        bus.sop_valid = 1'b1;
        bus.ts_in     = 64'h0000_0005_0000_0100;
        cyc();
        bus.sop_valid = 1'b0;
        bus.ts_in     = 64'h0000_0005_0000_0200;
        for (int i = 0; i < 11; i++) cyc();
        bus.ptp_found = 1'b1;
        bus.ptp_infor = 32'h1ABC_0042;
        cyc();
        check("ex1_level", 96'(bus.q_level), 96'd1);
        check("ex1_data", bus.q_data, 96'h1ABC0042_0000000500000100);
        bus.ptp_found = 1'b0;
        cyc();
        bus.q_rd = 1'b1;
        cyc();
        bus.q_rd = 1'b0;
        check("ex1_popped", 96'(bus.q_empty), 96'd1);

        // Non-PTP SOP followed by second SOP; then found without SOP
        bus.sop_valid = 1'b1;
        bus.ts_in     = 64'hAAAA_AAAA_0000_0001;
        cyc();
        bus.ts_in     = 64'hBBBB_BBBB_0000_0002;
        cyc();
        bus.sop_valid = 1'b0;
        cyc();
        bus.ptp_found = 1'b1;
        bus.ptp_infor = 32'h2000_0007;
        cyc();
        check("tsB_data", bus.q_data, 96'h20000007_BBBBBBBB00000002);
        bus.ptp_found = 1'b0;
        bus.q_rd      = 1'b1;
        cyc();
        bus.q_rd      = 1'b0;
        bus.ptp_found = 1'b1;
        cyc();
        bus.ptp_found = 1'b0;
        cyc();
        check("idle_rise_empty", 96'(bus.q_empty), 96'd1);

        // Fill, overflow, push+pop when full, saturation
        for (int i = 0; i < DEPTH; i++)
            push_pkt({32'(i), $urandom}, {4'h3, 12'(i), 16'(i)}, 1'b0);
        for (int i = 0; i < 3; i++)
            push_pkt({32'hDEAD, $urandom}, 32'hDEAD_0000 | 32'(i), 1'b0);
        check("full_level", 96'(bus.q_level), 96'd16);
        check("full_ovf3", 96'(bus.q_ovf_cnt), 96'd3);
        check("full_head", bus.q_data[63:32], 96'd0);
        push_pkt(64'h0000_00FF_1234_5678, 32'h4FFF_00FF, 1'b1);
        check("pp_full_level", 96'(bus.q_level), 96'd16);
        check("pp_full_ovf", 96'(bus.q_ovf_cnt), 96'd3);
        for (int i = 0; i < 255; i++)
            push_pkt({$urandom, $urandom}, $urandom, 1'b0);
        check("ovf_sat", 96'(bus.q_ovf_cnt), 96'd255);

        // Drain 20 pops through the wrap
        bus.q_rd = 1'b1;
        for (int i = 0; i < 20; i++) cyc();
        bus.q_rd = 1'b0;
        check("drain_empty", 96'(bus.q_empty), 96'd1);
        check("drain_data", bus.q_data, 96'd0);

        // Same-cycle SOP and found rise
        bus.sop_valid = 1'b1;
        bus.ts_in     = 64'h1111_1111_2222_2222;
        cyc();
        bus.sop_valid = 1'b0;
        cyc();
        bus.sop_valid = 1'b1;
        bus.ts_in     = 64'h3333_3333_4444_4444;
        bus.ptp_found = 1'b1;
        bus.ptp_infor = 32'h5000_0001;
        cyc();
        check("same_old_ts", bus.q_data, 96'h50000001_1111111122222222);
        bus.sop_valid = 1'b0;
        bus.ptp_found = 1'b0;
        cyc();
        bus.ptp_found = 1'b1;
        bus.ptp_infor = 32'h6000_0002;
        bus.q_rd      = 1'b1;
        cyc();
        bus.ptp_found = 1'b0;
        bus.q_rd      = 1'b0;
        check("same_new_ts", bus.q_data, 96'h60000002_3333333344444444);
        cyc();

        // Random phase
        for (int i = 0; i < 600; i++) begin
            bus.ts_in     = {$urandom, $urandom};
            bus.sop_valid = ($urandom_range(3) == 0);
            bus.ptp_found = ($urandom_range(2) == 0) ? ~bus.ptp_found : bus.ptp_found;
            bus.ptp_infor = $urandom;
            bus.q_rd      = ($urandom_range(3) == 0);
            bus.q_clr     = ($urandom_range(79) == 0);
            cyc();
        end
        bus.sop_valid = 1'b0;
        bus.ptp_found = 1'b0;
        bus.q_rd      = 1'b0;
        bus.q_clr     = 1'b0;
        cyc();

        // Clear coincident with push, pop and SOP at level 5 / ovf 7
        bus.q_clr = 1'b1;
        cyc();
        bus.q_clr = 1'b0;
        for (int i = 0; i < DEPTH + 7; i++)
            push_pkt({$urandom, $urandom}, $urandom, 1'b0);
        bus.q_rd = 1'b1;
        for (int i = 0; i < 11; i++) cyc();
        bus.q_rd = 1'b0;
        check("pre_clr_level", 96'(bus.q_level), 96'd5);
        check("pre_clr_ovf", 96'(bus.q_ovf_cnt), 96'd7);
        bus.sop_valid = 1'b1;
        bus.ts_in     = 64'h7777_0000_0000_0007;
        cyc();
        bus.ts_in     = 64'h8888_0000_0000_0008;
        bus.ptp_found = 1'b1;
        bus.q_rd      = 1'b1;
        bus.q_clr     = 1'b1;
        cyc();
        bus.sop_valid = 1'b0;
        bus.ptp_found = 1'b0;
        bus.q_rd      = 1'b0;
        bus.q_clr     = 1'b0;
        check("clr_level", 96'(bus.q_level), 96'd0);
        check("clr_ovf", 96'(bus.q_ovf_cnt), 96'd0);
        cyc();
        bus.ptp_found = 1'b1;
        cyc();
        bus.ptp_found = 1'b0;
        check("clr_idle_nopush", 96'(bus.q_empty), 96'd1);
        cyc();

        // Asynchronous reset between clock edges, with entries queued and capture armed
        push_pkt(64'h9999_0000_0000_0001, 32'h7000_0001, 1'b0);
        push_pkt(64'h9999_0000_0000_0002, 32'h7000_0002, 1'b0);
        bus.sop_valid = 1'b1;
        bus.ts_in     = 64'h9999_0000_0000_0003;
        cyc();
        bus.sop_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_empty", 96'(bus.q_empty), 96'd1);
        check("arst_level", 96'(bus.q_level), 96'd0);
        check("arst_data", bus.q_data, 96'd0);
        check("arst_ovf", 96'(bus.q_ovf_cnt), 96'd0);
        #1 rst = 1'b0;
        model_reset();
        bus.ptp_found = 1'b1;
        cyc();
        bus.ptp_found = 1'b0;
        cyc();
        check("arst_disarmed", 96'(bus.q_empty), 96'd1);
        push_pkt(64'hABCD_0000_0000_0010, 32'h7000_0010, 1'b0);
        check("arst_resume", bus.q_data, 96'h70000010_ABCD000000000010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
